// File: rtl/even_counter_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// even_counter_run_ctrl_if
// Bundles the request, status and counter-observation signals exchanged
// between the run sequencer and its surroundings.
//   master : drives start/laps/pause/resume/abort and the counter value,
//            observes run/busy/paused/lap_cnt/done/err
//   slave  : the sequencer itself (mirror of master)
// ---------------------------------------------------------------------------
interface even_counter_run_ctrl_if #(
    parameter int LAP_W = 4
);
    logic             start;
    logic [LAP_W-1:0] laps;
    logic             pause;
    logic             resume;
    logic             abort;
    logic [3:0]       count;
    logic             run;
    logic             busy;
    logic             paused;
    logic [LAP_W-1:0] lap_cnt;
    logic             done;
    logic             err;

    modport master (
        output start, laps, pause, resume, abort, count,
        input  run, busy, paused, lap_cnt, done, err
    );

    modport slave (
        input  start, laps, pause, resume, abort, count,
        output run, busy, paused, lap_cnt, done, err
    );
endinterface

// File: rtl/even_counter_run_ctrl.sv
// ---------------------------------------------------------------------------
// even_counter_run_ctrl
// Run sequencer for the 4-bit even-step counter. Enables the counter for a
// programmed number of full laps, supports pause/resume/abort and reports
// progress (lap_cnt) and completion (done) or a zero-lap request (err).
// Ports:
//   clock : rising-edge clock shared with the counter
//   reset : asynchronous active-high reset
//   bus   : slave side of even_counter_run_ctrl_if
//           inputs  start, laps, pause, resume, abort, count
//           outputs run, busy, paused, lap_cnt, done, err (all registered)
// ---------------------------------------------------------------------------
module even_counter_run_ctrl #(
    parameter logic [3:0] TOP   = 4'd14,
    parameter int         LAP_W = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    even_counter_run_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [LAP_W-1:0] r_target;
    logic [LAP_W-1:0] r_lap_cnt;
    logic [LAP_W-1:0] w_target_next;
    logic [LAP_W-1:0] w_lap_cnt_next;
    logic [LAP_W-1:0] w_lap_cnt_inc;

    logic             r_run;
    logic             r_busy;
    logic             r_paused;
    logic             r_done;
    logic             r_err;
    logic             w_run;
    logic             w_busy;
    logic             w_paused;
    logic             w_done;
    logic             w_err;

    logic             w_accept;
    logic             w_lap_event;
    logic             w_final_lap;

    // A lap only counts while the counter is actually enabled; the counter
    // wraps from TOP at the same edge.
    assign w_lap_event   = (r_state == ST_RUN) && (bus.count == TOP);
    assign w_lap_cnt_inc = r_lap_cnt + LAP_W'(1);
    // lap_cnt is always below the target while running, so the increment
    // cannot wrap before it matches.
    assign w_final_lap   = w_lap_event && (w_lap_cnt_inc == r_target);
    assign w_accept      = (r_state == ST_IDLE) && bus.start && (bus.laps != '0);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; in RUN abort beats lap completion, which beats pause
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = ST_RUN;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    w_next = ST_IDLE;
                end else if (w_final_lap) begin
                    w_next = ST_DONE;
                end else if (bus.pause) begin
                    w_next = ST_PAUSE;
                end else begin
                    w_next = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (bus.abort) begin
                    w_next = ST_IDLE;
                end else if (bus.resume) begin
                    w_next = ST_RUN;
                end else begin
                    w_next = ST_PAUSE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Output decode: flags follow the upcoming state so they are valid
    // in the same cycle the state is; target/lap_cnt update on accept/lap
    always_comb begin
        w_run          = (w_next == ST_RUN);
        w_busy         = (w_next == ST_RUN) || (w_next == ST_PAUSE);
        w_paused       = (w_next == ST_PAUSE);
        w_done         = (w_next == ST_DONE);
        w_err          = (r_state == ST_IDLE) && bus.start && (bus.laps == '0);
        w_target_next  = r_target;
        w_lap_cnt_next = r_lap_cnt;
        if (w_accept) begin
            w_target_next  = bus.laps;
            w_lap_cnt_next = '0;
        end else if (w_lap_event && !bus.abort) begin
            // an aborted lap is not credited; lap_cnt then holds until
            // the next accepted start
            w_lap_cnt_next = w_lap_cnt_inc;
        end else begin
            w_lap_cnt_next = r_lap_cnt;
        end
    end

    // Output and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_run     <= 1'b0;
            r_busy    <= 1'b0;
            r_paused  <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_target  <= '0;
            r_lap_cnt <= '0;
        end else begin
            r_run     <= w_run;
            r_busy    <= w_busy;
            r_paused  <= w_paused;
            r_done    <= w_done;
            r_err     <= w_err;
            r_target  <= w_target_next;
            r_lap_cnt <= w_lap_cnt_next;
        end
    end

    assign bus.run     = r_run;
    assign bus.busy    = r_busy;
    assign bus.paused  = r_paused;
    assign bus.done    = r_done;
    assign bus.err     = r_err;
    assign bus.lap_cnt = r_lap_cnt;

endmodule

// File: tb/tb_even_counter_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_even_counter_run_ctrl
// Bench for the run sequencer. Contains the even-step counter it controls
// and a lap-level reference model (mode + laps done + goal + counter value).
// ---------------------------------------------------------------------------
module tb_even_counter_run_ctrl;

    logic clock;
    logic reset;
    logic [3:0] r_count;

    even_counter_run_ctrl_if #(.LAP_W(4)) bus();

    even_counter_run_ctrl #(.TOP(4'd14), .LAP_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // The controlled counter: 0,2,...,14,0 while run is high
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_count <= 4'd0;
        else if (bus.run) r_count <= (r_count == 4'd14) ? 4'd0 : r_count + 4'd2;
    end
    assign bus.count = r_count;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: mode 0 idle, 1 running, 2 held, 3 finished
    int         m_mode;
    int         m_goal;
    int         m_done_laps;
    logic [3:0] m_cnt;
    bit         m_err;

    task automatic model_reset();
        m_mode = 0; m_goal = 0; m_done_laps = 0; m_cnt = 4'd0; m_err = 1'b0;
    endtask

    task automatic model_edge(input bit s, input logic [3:0] l, input bit p, input bit r, input bit a);
        bit lap;
        m_err = 1'b0;
        lap = (m_mode == 1) && (m_cnt == 4'd14);
        if (m_mode == 1) m_cnt = m_cnt + 4'd2;  // 4-bit arithmetic wraps 14 -> 0
        if (m_mode == 0) begin
            if (s && l == 4'd0) m_err = 1'b1;
            else if (s) begin m_goal = int'(l); m_done_laps = 0; m_mode = 1; end
        end else if (m_mode == 1) begin
            if (a) m_mode = 0;
            else begin
                if (lap) m_done_laps = m_done_laps + 1;
                if (lap && m_done_laps == m_goal) m_mode = 3;
                else if (p) m_mode = 2;
            end
        end else if (m_mode == 2) begin
            if (a) m_mode = 0;
            else if (r) m_mode = 1;
        end else begin
            m_mode = 0;
        end
    endtask

    function automatic logic [4:0] exp_flags();
        return {m_mode == 1, m_mode == 1 || m_mode == 2, m_mode == 2, m_mode == 3, m_err};
    endfunction

    function automatic logic [4:0] dut_flags();
        return {bus.run, bus.busy, bus.paused, bus.done, bus.err};
    endfunction

    // Drive one cycle of requests, advance the model, sample 1 time unit after the edge
    task automatic go(input bit s, input logic [3:0] l, input bit p, input bit r, input bit a);
        bus.start = s; bus.laps = l; bus.pause = p; bus.resume = r; bus.abort = a;
        model_edge(s, l, p, r, a);
        @(posedge clock); #1;
        bus.start = 1'b0; bus.pause = 1'b0; bus.resume = 1'b0; bus.abort = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_cmp++;
        if (dut_flags() !== 5'b00000 || bus.lap_cnt !== 4'd0) begin
            n_bad++; $display("FAIL reset_outputs flags=%b lap_cnt=%0d required flags=00000 lap_cnt=0", dut_flags(), bus.lap_cnt);
        end
        reset = 1'b0;
        model_reset();
        go(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (dut_flags() !== 5'b00000 || r_count !== 4'd0) begin
            n_bad++; $display("FAIL reset_release flags=%b count=%0d required 00000/0", dut_flags(), r_count);
        end
    endtask

    task automatic test_two_laps();
        int run_hi = 0;
        int dn = 0;
        logic [3:0] prev = 4'd0;
        logic [3:0] steps[$];
        go(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) begin
            n_cmp++;
            if (dut_flags() !== exp_flags()) begin
                n_bad++; $display("FAIL two_laps_flags cyc=%0d got=%b required=%b", i, dut_flags(), exp_flags());
            end
            if (bus.run === 1'b1) run_hi++;
            if (bus.done === 1'b1) dn++;
            if (bus.lap_cnt !== prev) begin steps.push_back(bus.lap_cnt); prev = bus.lap_cnt; end
            go(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        end
        n_cmp++;
        if (run_hi != 16) begin n_bad++; $display("FAIL two_laps_run_cycles got=%0d required=16", run_hi); end
        n_cmp++;
        if (dn != 1) begin n_bad++; $display("FAIL two_laps_done_pulses got=%0d required=1", dn); end
        n_cmp++;
        if (steps.size() != 2 || steps[0] !== 4'd1 || steps[1] !== 4'd2) begin
            n_bad++; $display("FAIL two_laps_lap_steps got_n=%0d required 1->2", steps.size());
        end
        n_cmp++;
        if (r_count !== 4'd0 || bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL two_laps_end count=%0d busy=%b required 0/0", r_count, bus.busy);
        end
    endtask

    task automatic test_pause_resume();
        logic [3:0] seq[4] = '{4'd10, 4'd12, 4'd14, 4'd0};
        go(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20 && r_count !== 4'd6; i++) go(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (r_count !== 4'd6) begin n_bad++; $display("FAIL pause_reach6 count=%0d required=6", r_count); end
        go(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (bus.paused !== 1'b1 || bus.run !== 1'b0 || r_count !== 4'd8) begin
            n_bad++; $display("FAIL pause_hold paused=%b run=%b count=%0d required 1/0/8", bus.paused, bus.run, r_count);
        end
        for (int i = 0; i < 3; i++) begin
            go(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (r_count !== 4'd8 || dut_flags() !== exp_flags()) begin
                n_bad++; $display("FAIL pause_idle count=%0d flags=%b required 8/%b", r_count, dut_flags(), exp_flags());
            end
        end
        go(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (bus.run !== 1'b1 || bus.paused !== 1'b0) begin
            n_bad++; $display("FAIL resume_run run=%b paused=%b required 1/0", bus.run, bus.paused);
        end
        for (int i = 0; i < 4; i++) begin
            go(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (r_count !== seq[i] || bus.done !== (i == 3)) begin
                n_bad++; $display("FAIL resume_seq step=%0d count=%0d done=%b required %0d/%0d", i, r_count, bus.done, seq[i], (i == 3));
            end
        end
        go(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        go(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40 && !(bus.lap_cnt === 4'd1 && r_count === 4'd4); i++) go(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.lap_cnt !== 4'd1 || r_count !== 4'd4) begin
            n_bad++; $display("FAIL abort_setup lap_cnt=%0d count=%0d required 1/4", bus.lap_cnt, r_count);
        end
        go(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (bus.busy !== 1'b0 || bus.run !== 1'b0 || bus.done !== 1'b0 || bus.lap_cnt !== 4'd1 || r_count !== 4'd6) begin
                n_bad++; $display("FAIL abort_idle cyc=%0d busy=%b run=%b done=%b lap_cnt=%0d count=%0d required 0/0/0/1/6",
                                  i, bus.busy, bus.run, bus.done, bus.lap_cnt, r_count);
            end
            go(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_zero_and_ignored_start();
        go(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL zero_laps_err err=%b busy=%b required 1/0", bus.err, bus.busy);
        end
        go(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.err !== 1'b0) begin n_bad++; $display("FAIL zero_laps_pulse err=%b required 0", bus.err); end
        go(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        repeat (2) go(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        go(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.lap_cnt !== 4'd0 || bus.run !== 1'b1 || bus.err !== 1'b0) begin
            n_bad++; $display("FAIL ignored_start lap_cnt=%0d run=%b err=%b required 0/1/0", bus.lap_cnt, bus.run, bus.err);
        end
        for (int i = 0; i < 40 && bus.busy === 1'b1; i++) begin
            go(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (dut_flags() !== exp_flags()) begin
                n_bad++; $display("FAIL ignored_start_run got=%b required=%b", dut_flags(), exp_flags());
            end
        end
        n_cmp++;
        if (bus.lap_cnt !== 4'd2 || bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL ignored_start_target lap_cnt=%0d busy=%b required 2/0", bus.lap_cnt, bus.busy);
        end
        go(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_final_lap_pause();
        go(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20 && r_count !== 4'd14; i++) go(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        go(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (bus.done !== 1'b1 || bus.paused !== 1'b0 || bus.run !== 1'b0) begin
            n_bad++; $display("FAIL final_lap_pause done=%b paused=%b run=%b required 1/0/0", bus.done, bus.paused, bus.run);
        end
        go(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (dut_flags() !== 5'b00000 || r_count !== 4'd0) begin
            n_bad++; $display("FAIL final_lap_idle flags=%b count=%0d required 00000/0", dut_flags(), r_count);
        end
    endtask

    task automatic test_reset_mid();
        int run_hi = 0;
        int dn = 0;
        go(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        repeat (3) go(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        go(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (bus.paused !== 1'b1) begin n_bad++; $display("FAIL reset_mid_pause paused=%b required 1", bus.paused); end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (dut_flags() !== 5'b00000 || bus.lap_cnt !== 4'd0) begin
            n_bad++; $display("FAIL reset_mid_async flags=%b lap_cnt=%0d required 00000/0", dut_flags(), bus.lap_cnt);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
        go(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            if (bus.run === 1'b1) run_hi++;
            if (bus.done === 1'b1) dn++;
            go(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        end
        n_cmp++;
        if (run_hi != 8 || dn != 1 || r_count !== 4'd0) begin
            n_bad++; $display("FAIL reset_mid_relap run_cycles=%0d done=%0d count=%0d required 8/1/0", run_hi, dn, r_count);
        end
    endtask

    task automatic test_random();
        bit s, p, r, a;
        logic [3:0] l;
        for (int i = 0; i < 600; i++) begin
            s = ($urandom % 6) == 0;
            l = 4'($urandom % 4);
            p = ($urandom % 9) == 0;
            r = ($urandom % 4) == 0;
            a = ($urandom % 25) == 0;
            go(s, l, p, r, a);
            n_cmp++;
            if (dut_flags() !== exp_flags() || bus.lap_cnt !== 4'(m_done_laps) || r_count !== m_cnt) begin
                n_bad++; $display("FAIL random cyc=%0d flags=%b lap_cnt=%0d count=%0d required %b/%0d/%0d",
                                  i, dut_flags(), bus.lap_cnt, r_count, exp_flags(), m_done_laps, m_cnt);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.laps = 4'd0; bus.pause = 1'b0; bus.resume = 1'b0; bus.abort = 1'b0;
        model_reset();
        test_reset();
        test_two_laps();
        test_pause_resume();
        test_abort();
        test_zero_and_ignored_start();
        test_final_lap_pause();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
